sum_seq_ctrl: RTL and testbench

- Start/done-handshaked sequencer for the shared-adder summation datapath: A register, Sum register, output buffer, and one adder muxed between A+1 and Sum+A.
- Runs one "sum A while A < limit" job per start request, then latches the result into the output buffer.
- Aborts on request; an iteration watchdog flags runaway jobs.
- Sits between the top-level command logic and the datapath; the datapath supplies the compare flag.

---
 rtl/sum_seq_ctrl.sv | 79 +++++++
 tb/tb_sum_seq_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: start/done sequencer for the shared-adder "sum A while A < limit" datapath
//   iClk/iRst          clock, async active-high reset
//   iStart/iAbort      job request (IDLE only) / cancel job or clear error
//   iAlt               datapath compare, A < latched limit
//   oLimitLoad..oOutBufSel  datapath strobes (Moore, decoded from state)
//   oBusy/oDone/oErr   status; oIterCnt completed iterations of current/last job
module sum_seq_ctrl #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iAlt,
  output logic              oLimitLoad,
  output logic              oASrcSel,
  output logic              oALoad,
  output logic              oSumSrcSel,
  output logic              oSumLoad,
  output logic              oAddSrcSel,
  output logic              oOutBufSel,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic [ITER_W-1:0] oIterCnt
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_ADD  = 3'd3;
  localparam logic [2:0] S_INC  = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;
  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ITER_W-1:0] r_cnt;
  logic              w_abort;
  // IDLE and DONE are not abortable; DONE always completes its pulse
  assign w_abort = iAbort && r_state != S_IDLE && r_state != S_DONE;
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = iStart ? S_INIT : S_IDLE;
      S_INIT: w_next = S_CMP;
      S_CMP:  w_next = !iAlt ? S_OUT : (r_cnt == ITER_W'(MAX_ITER) ? S_ERR : S_ADD);
      S_ADD:  w_next = S_INC;
      S_INC:  w_next = S_CMP;
      S_OUT:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      S_ERR:  w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // an aborted cycle leaves the counter untouched
      if (!w_abort && r_state == S_INIT) r_cnt <= '0;
      else if (!w_abort && r_state == S_INC && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign oLimitLoad = r_state == S_INIT;
  assign oASrcSel   = r_state == S_INC;
  assign oALoad     = r_state == S_INIT || r_state == S_INC;
  assign oSumSrcSel = r_state == S_ADD;
  assign oSumLoad   = r_state == S_INIT || r_state == S_ADD;
  assign oAddSrcSel = r_state == S_ADD;
  assign oOutBufSel = r_state == S_OUT;
  assign oBusy      = r_state != S_IDLE && r_state != S_DONE && r_state != S_ERR;
  assign oDone      = r_state == S_DONE;
  assign oErr       = r_state == S_ERR;
  assign oIterCnt   = r_cnt;
endmodule

// File: tb/tb_sum_seq_ctrl.sv
// tb_sum_seq_ctrl: directed bench with a datapath model and per-cycle strobe scoreboard
module tb_sum_seq_ctrl;
  localparam int IDLE = 0, INIT = 1, CMP = 2, ADD = 3, INC = 4, OUT = 5, DONE = 6, ERR = 7;
  logic clk = 0, rst = 1;
  logic start = 0, abrt = 0, alt;
  logic start2 = 0, abrt2 = 0, alt2 = 1;
  // {LimitLoad, ASrcSel, ALoad, SumSrcSel, SumLoad, AddSrcSel, OutBufSel, Busy, Done, Err}
  logic [9:0] v1, v2;
  logic [7:0] cnt1, cnt2;
  logic [7:0] ma, mlim, lim = 0;
  logic [15:0] msum, madd;
  int n_chk = 0, n_fail = 0, nsl, nob;
  always #5 clk = ~clk;
  sum_seq_ctrl dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iAbort(abrt), .iAlt(alt),
    .oLimitLoad(v1[9]), .oASrcSel(v1[8]), .oALoad(v1[7]), .oSumSrcSel(v1[6]),
    .oSumLoad(v1[5]), .oAddSrcSel(v1[4]), .oOutBufSel(v1[3]), .oBusy(v1[2]),
    .oDone(v1[1]), .oErr(v1[0]), .oIterCnt(cnt1)
  );
  sum_seq_ctrl #(.ITER_W(8), .MAX_ITER(4)) dut2 (
    .iClk(clk), .iRst(rst), .iStart(start2), .iAbort(abrt2), .iAlt(alt2),
    .oLimitLoad(v2[9]), .oASrcSel(v2[8]), .oALoad(v2[7]), .oSumSrcSel(v2[6]),
    .oSumLoad(v2[5]), .oAddSrcSel(v2[4]), .oOutBufSel(v2[3]), .oBusy(v2[2]),
    .oDone(v2[1]), .oErr(v2[0]), .oIterCnt(cnt2)
  );
  // shared-adder datapath driven by dut's strobes
  assign madd = v1[4] ? msum + 16'(ma) : 16'(ma) + 16'd1;
  assign alt = ma < mlim;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= 0;
      mlim <= 0;
      msum <= 0;
    end else begin
      if (v1[9]) mlim <= lim;
      if (v1[7]) ma <= v1[8] ? madd[7:0] : 8'd0;
      if (v1[5]) msum <= v1[6] ? madd : 16'd0;
    end
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  function automatic logic [9:0] ev(input int s);
    case (s)
      INIT: return 10'b1010100100;
      CMP:  return 10'b0000000100;
      ADD:  return 10'b0001110100;
      INC:  return 10'b0110000100;
      OUT:  return 10'b0000001100;
      DONE: return 10'b0000000010;
      ERR:  return 10'b0000000001;
      default: return 10'b0;
    endcase
  endfunction
  // expected state in cycle c of a job with n loop iterations started at edge 0
  function automatic int sched(input int n, input int c);
    if (c == 1) return INIT;
    if (c >= 2 && c <= 3 * n + 1) return (c - 2) % 3 == 0 ? CMP : ((c - 2) % 3 == 1 ? ADD : INC);
    if (c == 3 * n + 2) return CMP;
    if (c == 3 * n + 3) return OUT;
    if (c == 3 * n + 4) return DONE;
    return IDLE;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run(input string tag, input bit w, input int n, input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      tick();
      check($sformatf("%s_c%0d", tag, c), 32'(w ? v2 : v1), 32'(ev(sched(n, c))));
      if (!w && v1[5]) nsl++;
      if (!w && v1[3]) nob++;
    end
  endtask
  initial begin
    #1;
    check("rst_vec", 32'(v1), 32'd0);
    check("rst_cnt", 32'(cnt1), 32'd0);
    check("rst_vec2", 32'(v2), 32'd0);
    #2 rst = 0;
    lim = 10; nsl = 0; nob = 0;
    start = 1;
    run("j10", 0, 10, 1, 1);
    start = 0;
    run("j10", 0, 10, 2, 36);
    check("j10_cnt", 32'(cnt1), 32'd10);
    check("j10_sumload", 32'(nsl), 32'd11);
    check("j10_outbuf", 32'(nob), 32'd1);
    check("j10_sum", 32'(msum), 32'd45);
    lim = 0; nsl = 0; nob = 0;
    start = 1;
    run("j0", 0, 0, 1, 1);
    start = 0;
    run("j0", 0, 0, 2, 6);
    check("j0_cnt", 32'(cnt1), 32'd0);
    check("j0_sumload", 32'(nsl), 32'd1);
    check("j0_outbuf", 32'(nob), 32'd1);
    lim = 10;
    start = 1;
    run("pre_rst", 0, 10, 1, 1);
    start = 0;
    run("pre_rst", 0, 10, 2, 7);
    check("pre_rst_cnt", 32'(cnt1), 32'd1);
    #2 rst = 1;
    #1;
    check("midrst_vec", 32'(v1), 32'd0);
    check("midrst_cnt", 32'(cnt1), 32'd0);
    #1 rst = 0;
    lim = 3;
    start = 1;
    run("post_rst", 0, 3, 1, 1);
    start = 0;
    run("post_rst", 0, 3, 2, 16);
    check("post_rst_cnt", 32'(cnt1), 32'd3);
    check("post_rst_sum", 32'(msum), 32'd3);
    lim = 10; nob = 0;
    start = 1;
    run("abort", 0, 10, 1, 9);
    abrt = 1;
    start = 0;
    tick();
    check("abort_idle", 32'(v1), 32'd0);
    check("abort_cnt", 32'(cnt1), 32'd2);
    abrt = 0;
    run("post_abort", 0, 10, 100, 103);
    check("abort_outbuf", 32'(nob), 32'd0);
    lim = 0;
    start = 1;
    run("b2b", 0, 0, 1, 5);
    tick();
    check("b2b_restart", 32'(v1), 32'(ev(INIT)));
    start = 0;
    run("b2b2", 0, 0, 2, 6);
    start2 = 1;
    run("err", 1, 4, 1, 14);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("err_sticky%0d", i), 32'(v2), 32'(ev(ERR)));
    end
    check("err_cnt", 32'(cnt2), 32'd4);
    abrt2 = 1;
    start2 = 0;
    tick();
    check("err_clear", 32'(v2), 32'd0);
    abrt2 = 0;
    tick();
    check("err_idle", 32'(v2), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
